// File: rtl/aes_v2_pkg.sv
// Shared definitions for the lightweight AES functional unit:
// GF(2^8) reduction constant, InvMixColumns coefficients, fsm encoding
// and small GF helpers built on xtime.
package aes_v2_pkg;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] AES_POLY = 8'h1b;

    // InvMixColumns row coefficients
    localparam logic [7:0] COEF_0E = 8'h0e;
    localparam logic [7:0] COEF_0B = 8'h0b;
    localparam logic [7:0] COEF_0D = 8'h0d;
    localparam logic [7:0] COEF_09 = 8'h09;

    // Byte-position counter for the one-byte-per-cycle datapath
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } fsm_t;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by a constant below 0x10 using the x2/x4/x8 chain
    function automatic logic [7:0] gf_mul_c4(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? x  : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^
               (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_v2_invmix_byte.sv
// Combinational InvMixColumns row: y = 0e*x0 ^ 0b*x1 ^ 0d*x2 ^ 09*x3.
module aes_v2_invmix_byte
    import aes_v2_pkg::*;
(
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [7:0] x3,
    output logic [7:0] y
);

    // One output byte of the inverse column mix
    always_comb begin
        y = gf_mul_c4(x0, COEF_0E[3:0]) ^
            gf_mul_c4(x1, COEF_0B[3:0]) ^
            gf_mul_c4(x2, COEF_0D[3:0]) ^
            gf_mul_c4(x3, COEF_09[3:0]);
    end

endmodule

// File: rtl/aes_v2_invmix_size.sv
// Size-optimised InvMixColumns: one output byte per cycle through a single
// shared GF MAC; bytes 0..2 are held in registers and byte 3 is combined
// combinationally in the completing cycle.
module aes_v2_invmix_size
    import aes_v2_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    output logic        ready,
    output logic [31:0] rd
);

    fsm_t        fsm;
    logic [7:0]  b0_q;
    logic [7:0]  b1_q;
    logic [7:0]  b2_q;
    logic [31:0] rot;
    logic [7:0]  b_cur;

    // Rotate the column right so the byte being produced sits in the low lane
    always_comb begin
        rot = rs1;
        case (fsm)
            S0:      rot = rs1;
            S1:      rot = {rs1[7:0],  rs1[31:8]};
            S2:      rot = {rs1[15:0], rs1[31:16]};
            S3:      rot = {rs1[23:0], rs1[31:24]};
            default: rot = rs1;
        endcase
    end

    aes_v2_invmix_byte u_mac (
        .x0 (rot[7:0]),
        .x1 (rot[15:8]),
        .x2 (rot[23:16]),
        .x3 (rot[31:24]),
        .y  (b_cur)
    );

    // Completion and gated result
    always_comb begin
        ready = valid && (fsm == S3);
        rd    = ready ? {b_cur, b2_q, b1_q, b0_q} : '0;
    end

    // Byte counter and partial-result capture; dropping valid aborts to S0
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            fsm  <= S0;
            b0_q <= '0;
            b1_q <= '0;
            b2_q <= '0;
        end else if (!valid) begin
            fsm <= S0;
        end else begin
            case (fsm)
                S0: begin
                    b0_q <= b_cur;
                    fsm  <= S1;
                end
                S1: begin
                    b1_q <= b_cur;
                    fsm  <= S2;
                end
                S2: begin
                    b2_q <= b_cur;
                    fsm  <= S3;
                end
                S3: begin
                    fsm <= S0;
                end
                default: fsm <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_v2_invmix_size.sv
`timescale 1ns/1ps
module tb_aes_v2_invmix_size;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] rs1 = '0;
    logic        ready;
    logic [31:0] rd;

    int checks = 0;
    int failures = 0;
    logic exp_ready = 1'b0;
    logic [31:0] exp_q[$];

    aes_v2_invmix_size dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .valid   (valid),
        .rs1     (rs1),
        .ready   (ready),
        .rd      (rd)
    );

    always #5 g_clk = ~g_clk;

    // Reference GF(2^8) multiply by shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] c, input logic inverse);
        logic [7:0] a[4];
        logic [7:0] b[4];
        logic [7:0] k0, k1, k2, k3;
        for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
        if (inverse) begin k0 = 8'h0e; k1 = 8'h0b; k2 = 8'h0d; k3 = 8'h09; end
        else         begin k0 = 8'h02; k1 = 8'h03; k2 = 8'h01; k3 = 8'h01; end
        for (int i = 0; i < 4; i++)
            b[i] = gmul(a[i], k0) ^ gmul(a[(i+1)%4], k1) ^
                   gmul(a[(i+2)%4], k2) ^ gmul(a[(i+3)%4], k3);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One full instruction: valid held for four cycles, result expected in the last
    task automatic do_op(input logic [31:0] data, input logic [31:0] exp);
        exp_q.push_back(exp);
        for (int c = 0; c < 4; c++) begin
            @(posedge g_clk); #1;
            valid = 1'b1;
            rs1 = data;
            exp_ready = (c == 3);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge g_clk); #1;
            valid = 1'b0;
            exp_ready = 1'b0;
        end
    endtask

    // Monitor: every cycle, check ready timing; on ready pop and compare rd
    initial begin
        forever begin
            @(negedge g_clk);
            chk("ready", {31'd0, ready}, {31'd0, exp_ready});
            if (ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got rd %h with no pending request", rd);
                end else begin
                    chk("rd", rd, exp_q.pop_front());
                end
            end else begin
                chk("rd_idle", rd, 32'h0);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x;
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b0;
        idle(1);

        do_op(32'hbca14d8e, 32'h455313db);
        idle(1);
        do_op(32'h9d58dc9f, 32'h5c220af2);
        do_op(32'h01010101, 32'h01010101);
        do_op(32'h00000000, 32'h00000000);
        do_op(32'hc6c6c6c6, 32'hc6c6c6c6);
        idle(2);

        // Abort: two cycles of valid, one low, then a full request
        for (int c = 0; c < 2; c++) begin
            @(posedge g_clk); #1;
            valid = 1'b1; rs1 = 32'h12345678; exp_ready = 1'b0;
        end
        idle(1);
        do_op(32'hbca14d8e, 32'h455313db);
        idle(1);

        // Reset asserted while in S2
        for (int c = 0; c < 3; c++) begin
            @(posedge g_clk); #1;
            valid = 1'b1; rs1 = 32'hdeadbeef; exp_ready = 1'b0;
        end
        #2 g_reset = 1'b1;
        valid = 1'b0;
        #1;
        chk("reset_ready", {31'd0, ready}, 32'h0);
        chk("reset_rd", rd, 32'h0);
        chk("reset_fsm", {30'd0, dut.fsm}, 32'h0);
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        do_op(32'h9d58dc9f, 32'h5c220af2);
        idle(1);

        // Random columns, alternating model check and InvMix(Mix(x)) round trip
        for (int n = 0; n < 10000; n++) begin
            x = $urandom;
            if (n % 2 == 0) do_op(x, ref_mix(x, 1'b1));
            else            do_op(ref_mix(x, 1'b0), x);
        end
        idle(3);

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
